// File: rtl/sensor_clk_gen.sv
// sensor_clk_gen: programmable glitch-free clock divider with edge strobes, graceful stop and period counter
module sensor_clk_gen #(
   parameter int CNT_W    = 16,
   parameter int DEF_DIV  = 20,
   parameter int DEF_HIGH = 10,
   parameter int PCNT_W   = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [CNT_W-1:0]  cfg_div,
   input  logic [CNT_W-1:0]  cfg_high,
   output logic              cfg_err,
   output logic              clk_out,
   output logic              rise_tick,
   output logic              fall_tick,
   output logic              running,
   output logic [PCNT_W-1:0] period_cnt
);
   typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;
   state_t state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_inc, div, high, pd_div, pd_high;
   logic pend, cfg_ok, acc, bnd;
   assign cfg_ready = !pend;
   assign running = state != IDLE;
   always_comb begin
      cfg_ok = cfg_div >= CNT_W'(2) && cfg_high != '0 && cfg_high < cfg_div;
      acc = cfg_valid && cfg_ready && cfg_ok;
      cnt_inc = cnt + CNT_W'(1);
      bnd = state != IDLE && cnt == div - CNT_W'(1);
      state_nxt = en ? RUN : (state == IDLE || bnd) ? IDLE : STOP;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         div        <= CNT_W'(DEF_DIV);
         high       <= CNT_W'(DEF_HIGH);
         pend       <= 1'b0;
         pd_div     <= '0;
         pd_high    <= '0;
         clk_out    <= 1'b0;
         rise_tick  <= 1'b0;
         fall_tick  <= 1'b0;
         cfg_err    <= 1'b0;
         period_cnt <= '0;
      end else begin
         state     <= state_nxt;
         cfg_err   <= cfg_valid && cfg_ready && !cfg_ok;
         rise_tick <= 1'b0;
         fall_tick <= 1'b0;
         // A new period starts only from IDLE or at a boundary; high < div keeps clk_out low there
         if (state == IDLE || bnd) begin
            if (pend) begin
               div  <= pd_div;
               high <= pd_high;
               pend <= 1'b0;
            end
            if (bnd) period_cnt <= period_cnt + PCNT_W'(1);
            cnt       <= '0;
            clk_out   <= en;
            rise_tick <= en;
         end else begin
            cnt       <= cnt_inc;
            clk_out   <= cnt_inc < high;
            fall_tick <= cnt_inc == high;
         end
         if (acc && state == IDLE) begin
            div  <= cfg_div;
            high <= cfg_high;
         end else if (acc) begin
            pend    <= 1'b1;
            pd_div  <= cfg_div;
            pd_high <= cfg_high;
         end
      end
   end
endmodule

// File: tb/tb_sensor_clk_gen.sv
// tb_sensor_clk_gen: scoreboard bench; a waveform-queue model predicts every output each cycle
module tb_sensor_clk_gen;
   localparam int CNT_W = 16;
   localparam int PCNT_W = 4;
   logic clk = 1'b0;
   logic rst = 1'b1, en = 1'b0, cfg_valid = 1'b0;
   logic [CNT_W-1:0] cfg_div = '0, cfg_high = '0;
   logic cfg_ready, cfg_err, clk_out, rise_tick, fall_tick, running;
   logic [PCNT_W-1:0] period_cnt;
   sensor_clk_gen #(.CNT_W(CNT_W), .DEF_DIV(20), .DEF_HIGH(10), .PCNT_W(PCNT_W)) dut (
      .clk(clk), .rst(rst), .en(en), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_div(cfg_div), .cfg_high(cfg_high), .cfg_err(cfg_err), .clk_out(clk_out),
      .rise_tick(rise_tick), .fall_tick(fall_tick), .running(running), .period_cnt(period_cnt)
   );
   always #5 clk = ~clk;
   typedef struct {bit c; bit r; bit f; bit run; bit rdy; bit err; int pc;} exp_t;
   exp_t sb[$];
   int n_chk = 0, n_fail = 0;
   bit done = 0;
   // reference model: the remaining samples of the current period are held in a queue
   bit wave[$];
   bit m_clk, m_run, m_pend, m_err, m_rise, m_fall;
   int m_div, m_high, m_pdiv, m_phigh, m_pc;
   task automatic start_period();
      m_run = 1;
      for (int i = 0; i < m_div; i++) wave.push_back(i < m_high);
      m_clk = wave.pop_front();
   endtask
   task automatic model_step(bit r, bit e, bit v, int d, int h);
      bit ok, acc, prev;
      if (r) begin
         wave.delete();
         m_clk = 0; m_run = 0; m_pend = 0; m_err = 0; m_rise = 0; m_fall = 0;
         m_div = 20; m_high = 10; m_pc = 0;
         return;
      end
      ok = d >= 2 && h >= 1 && h < d;
      acc = v && !m_pend;
      prev = m_clk;
      m_err = acc && !ok;
      if (!m_run || wave.size() == 0) begin
         if (m_run) m_pc = (m_pc + 1) % (1 << PCNT_W);
         if (m_pend) begin m_div = m_pdiv; m_high = m_phigh; m_pend = 0; end
         if (acc && ok && !m_run) begin m_div = d; m_high = h; end
         else if (acc && ok) begin m_pend = 1; m_pdiv = d; m_phigh = h; end
         if (e) start_period();
         else begin m_run = 0; m_clk = 0; end
      end else begin
         m_clk = wave.pop_front();
         if (acc && ok) begin m_pend = 1; m_pdiv = d; m_phigh = h; end
      end
      m_rise = m_clk && !prev;
      m_fall = !m_clk && prev;
   endtask
   task automatic cyc(bit r, bit e, bit v = 0, int d = 0, int h = 0);
      exp_t x;
      @(negedge clk);
      rst = r; en = e; cfg_valid = v; cfg_div = CNT_W'(d); cfg_high = CNT_W'(h);
      model_step(r, e, v, d, h);
      x.c = m_clk; x.r = m_rise; x.f = m_fall; x.run = m_run;
      x.rdy = !m_pend; x.err = m_err; x.pc = m_pc;
      sb.push_back(x);
   endtask
   task automatic chk(string n, int a, int e);
      n_chk++;
      if (a !== e) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0d expected %0d", n, $time, a, e);
      end
   endtask
   initial begin : monitor
      exp_t x;
      forever begin
         @(posedge clk);
         #1;
         if (done) break;
         if (sb.size() != 0) begin
            x = sb.pop_front();
            chk("clk_out", int'(clk_out), int'(x.c));
            chk("rise_tick", int'(rise_tick), int'(x.r));
            chk("fall_tick", int'(fall_tick), int'(x.f));
            chk("running", int'(running), int'(x.run));
            chk("cfg_ready", int'(cfg_ready), int'(x.rdy));
            chk("cfg_err", int'(cfg_err), int'(x.err));
            chk("period_cnt", int'(period_cnt), x.pc);
         end
      end
   end
   initial begin : stim
      bit e;
      int d;
      repeat (3) cyc(1, 0);
      repeat (45) cyc(0, 1);
      cyc(0, 1, 1, 8, 2);
      repeat (35) cyc(0, 1);
      cyc(0, 1, 1, 1, 1); cyc(0, 1);
      cyc(0, 1, 1, 5, 0); cyc(0, 1);
      cyc(0, 1, 1, 5, 5);
      repeat (10) cyc(0, 1);
      cyc(0, 1, 1, 20, 10);
      repeat (23) cyc(0, 1);
      repeat (30) cyc(0, 0);
      repeat (6) cyc(0, 1);
      repeat (4) cyc(0, 0);
      repeat (30) cyc(0, 1);
      cyc(0, 1, 1, 12, 12);
      cyc(0, 1, 1, 6, 3);
      repeat (3) cyc(0, 0);
      repeat (20) cyc(0, 1);
      cyc(1, 1);
      repeat (25) cyc(0, 1);
      e = 1;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 29) == 0) e = !e;
         d = $urandom_range(0, 12);
         cyc($urandom_range(0, 499) == 0, e, $urandom_range(0, 9) == 0, d, $urandom_range(0, d + 1));
      end
      repeat (2) @(negedge clk);
      done = 1;
      chk("scoreboard_drain", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
